// File: rtl/adpll_tdc_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : adpll_tdc_pkg
// Contents : TDC decoder widths, FSM state encoding and phase-word layout.
// Revision : 1.0
// ============================================================================
package adpll_tdc_pkg;

    localparam int N_TAPS = 16;
    localparam int FRAC_W = 4;
    localparam int RC_W   = 7;
    localparam int INT_W  = RC_W + 1;
    localparam int W      = INT_W + FRAC_W;
    localparam int CNT_W  = FRAC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef struct packed {
        logic [INT_W-1:0]  ipart;
        logic [FRAC_W-1:0] frac;
    } tdc_word_t;

endpackage
`default_nettype wire

// File: rtl/adpll_tdc_decoder_if.sv
`default_nettype none
// ============================================================================
// Interface : adpll_tdc_decoder_if
// Contents  : TDC sample inputs and decoded phase-word outputs.
// Revision  : 1.0
// ============================================================================
interface adpll_tdc_decoder_if;
    import adpll_tdc_pkg::*;

    logic              en;
    logic [RC_W-1:0]   tdc_ripple_count;
    logic [N_TAPS-1:0] tdc_phase;
    logic [W-1:0]      tdc_word;
    logic              word_valid;
    logic [W-1:0]      delta_word;
    logic              delta_valid;
    logic              code_err;
    logic              code_err_sticky;

    modport master (
        output en, tdc_ripple_count, tdc_phase,
        input  tdc_word, word_valid, delta_word, delta_valid, code_err, code_err_sticky
    );

    modport slave (
        input  en, tdc_ripple_count, tdc_phase,
        output tdc_word, word_valid, delta_word, delta_valid, code_err, code_err_sticky
    );
endinterface
`default_nettype wire

// File: rtl/adpll_tdc_decoder_therm_decode.sv
`default_nettype none
// ============================================================================
// Module   : tdc_therm_decode
// Contents : Bubble-correcting thermometer decoder with validity flag.
// Revision : 1.0
// ============================================================================
module tdc_therm_decode
    import adpll_tdc_pkg::*;
(
    input  wire logic [N_TAPS-1:0] i_phase,
    output logic      [CNT_W-1:0]  o_count,
    output logic                   o_valid
);
    // Bit 0 is the virtual tap below the earliest (always 1), the top bit the
    // virtual tap above the last (always 0).
    logic [N_TAPS+1:0] w_ext;
    logic [N_TAPS-1:0] w_corr;
    logic [N_TAPS:0]   w_corr_x;

    assign w_ext = {1'b0, i_phase, 1'b1};

    generate
        for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_maj
            assign w_corr[gi] = (w_ext[gi]   & w_ext[gi+1]) |
                                (w_ext[gi]   & w_ext[gi+2]) |
                                (w_ext[gi+1] & w_ext[gi+2]);
        end
    endgenerate

    // A pure 2^k-1 pattern has no bit in common with itself plus one.
    assign w_corr_x = {1'b0, w_corr};
    assign o_valid  = ((w_corr_x & (w_corr_x + (N_TAPS+1)'(1))) == '0);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            o_count = o_count + CNT_W'(w_corr[i]);
        end
    end
endmodule
`default_nettype wire

// File: rtl/adpll_tdc_decoder.sv
`default_nettype none
// ============================================================================
// Module   : adpll_tdc_decoder
// Contents : TDC back-end: capture, thermometer decode, integer unwrap, delta.
// Revision : 1.0
// ============================================================================
module adpll_tdc_decoder
    import adpll_tdc_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    adpll_tdc_decoder_if.slave bus
);
    state_t r_state;
    state_t w_state_nxt;
    logic   w_cap_en;
    logic   w_cap_run;

    logic              r_s1_vld;
    logic              r_s1_run;
    logic [RC_W-1:0]   r_s1_rip;
    logic [N_TAPS-1:0] r_s1_phase;

    logic [CNT_W-1:0]  w_cnt;
    logic              w_code_ok;
    logic [FRAC_W-1:0] w_frac;
    logic              w_carry;
    logic              w_wrap_nxt;
    tdc_word_t         w_s2_word;

    logic              r_wrap;
    logic [RC_W-1:0]   r_prev_rip;
    logic [FRAC_W-1:0] r_prev_frac;
    logic              r_prev_carry;

    logic              r_s2_vld;
    logic              r_s2_run;
    logic              r_s2_err;
    logic [W-1:0]      r_s2_word;

    logic [W-1:0]      r_word;
    logic              r_wv;
    logic [W-1:0]      r_delta;
    logic              r_dv;
    logic              r_err;
    logic              r_sticky;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // A sample captured while leaving IDLE is the PRIME sample; every later
    // sample in the same enable window is a RUN sample.
    always_comb begin
        w_state_nxt = r_state;
        w_cap_en    = bus.en;
        w_cap_run   = 1'b0;
        if (!bus.en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = PRIME;
                PRIME:   begin w_state_nxt = RUN; w_cap_run = 1'b1; end
                RUN:     begin w_state_nxt = RUN; w_cap_run = 1'b1; end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_run   <= 1'b0;
            r_s1_rip   <= '0;
            r_s1_phase <= '0;
        end else begin
            r_s1_vld <= w_cap_en;
            r_s1_run <= w_cap_run;
            if (w_cap_en) begin
                r_s1_rip   <= bus.tdc_ripple_count;
                r_s1_phase <= bus.tdc_phase;
            end
        end
    end

    tdc_therm_decode u_therm (
        .i_phase (r_s1_phase),
        .o_count (w_cnt),
        .o_valid (w_code_ok)
    );

    always_comb begin
        w_frac  = r_prev_frac;
        w_carry = r_prev_carry;
        if (w_code_ok) begin
            w_frac  = w_cnt[FRAC_W-1:0];
            w_carry = w_cnt[FRAC_W];
        end
        w_wrap_nxt      = r_s1_run ? (r_wrap ^ (r_s1_rip < r_prev_rip)) : 1'b0;
        w_s2_word.ipart = {w_wrap_nxt, r_s1_rip} + INT_W'(w_carry);
        w_s2_word.frac  = w_frac;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap       <= 1'b0;
            r_prev_rip   <= '0;
            r_prev_frac  <= '0;
            r_prev_carry <= 1'b0;
            r_s2_vld     <= 1'b0;
            r_s2_run     <= 1'b0;
            r_s2_err     <= 1'b0;
            r_s2_word    <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            r_s2_run <= r_s1_run;
            r_s2_err <= r_s1_vld & ~w_code_ok;
            if (r_s1_vld) begin
                r_s2_word  <= w_s2_word;
                r_wrap     <= w_wrap_nxt;
                r_prev_rip <= r_s1_rip;
                if (w_code_ok) begin
                    r_prev_frac  <= w_frac;
                    r_prev_carry <= w_carry;
                end
            end else if (r_state == IDLE) begin
                r_wrap <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word   <= '0;
            r_wv     <= 1'b0;
            r_delta  <= '0;
            r_dv     <= 1'b0;
            r_err    <= 1'b0;
            r_sticky <= 1'b0;
        end else if (r_s2_vld) begin
            r_word   <= r_s2_word;
            r_wv     <= 1'b1;
            r_dv     <= r_s2_run;
            r_delta  <= r_s2_run ? (r_s2_word - r_word) : '0;
            r_err    <= r_s2_err;
            r_sticky <= r_sticky | r_s2_err;
        end else begin
            r_wv  <= 1'b0;
            r_dv  <= 1'b0;
            r_err <= 1'b0;
        end
    end

    assign bus.tdc_word        = r_word;
    assign bus.word_valid      = r_wv;
    assign bus.delta_word      = r_delta;
    assign bus.delta_valid     = r_dv;
    assign bus.code_err        = r_err;
    assign bus.code_err_sticky = r_sticky;
endmodule
`default_nettype wire
